minterm_sweep_checker: RTL and testbench

Self-checking exhaustive stimulus engine for combinational sum-of-minterms blocks. Parametrised in input count, settle time and expected truth table, so it replaces hand-written per-function sweep loops. On `start` it drives every input vector 0 … 2^N_IN−1 into a device under test and compares the DUT output against a latched minterm mask. It reports the mismatch count, the first failing vector and a pass flag. It sits between the function block and the project's top-level bench/board wrapper.

---
 rtl/minterm_sweep_checker.sv | 202 ++++++++++++++++++++
 tb/tb_minterm_sweep_checker.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/minterm_sweep_checker.sv
// -----------------------------------------------------------------------------
// minterm_sweep_checker
//
// Exhaustive stimulus engine for combinational sum-of-minterms blocks. When a
// sweep is started it walks dut_in through every vector 0 .. 2^N_IN-1. Each
// vector is held for SETTLE cycles and then compared for one cycle. The DUT
// response is checked against a truth table latched at start. The block
// reports the mismatch count, the lowest failing vector and a pass flag.
//
// Parameters
//   N_IN      number of DUT inputs (1..8); dut_in MSB is input W/A
//   SETTLE    cycles a vector is held before its compare cycle (>= 1)
//   DEF_MASK  reset value of the 2^N_IN-bit mask register
//
// Ports
//   clk               in   single clock, rising edge
//   rst               in   asynchronous active-high reset
//   start             in   begin a sweep (honoured only in IDLE or DONE)
//   stop_on_fail      in   captured with start; end sweep at first mismatch
//   exp_mask          in   expected truth table, bit k = output for vector k
//   dut_out           in   DUT output under test
//   dut_in            out  vector driven to the DUT (registered)
//   busy              out  sweep in progress
//   done              out  sweep finished, held until next start or reset
//   pass              out  done and no mismatches
//   err_count         out  number of mismatching vectors (0 .. 2^N_IN)
//   first_fail_valid  out  at least one mismatch recorded
//   first_fail_idx    out  lowest-index failing vector
// -----------------------------------------------------------------------------
module minterm_sweep_checker #(
    parameter int                      N_IN     = 4,
    parameter int                      SETTLE   = 2,
    parameter logic [(1<<N_IN)-1:0]    DEF_MASK = 16'hDF03
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   stop_on_fail,
    input  logic [(1<<N_IN)-1:0]   exp_mask,
    input  logic                   dut_out,
    output logic [N_IN-1:0]        dut_in,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [N_IN:0]          err_count,
    output logic                   first_fail_valid,
    output logic [N_IN-1:0]        first_fail_idx
);

    localparam int NVEC   = 1 << N_IN;
    localparam int ERR_W  = N_IN + 1;
    localparam int WAIT_W = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
    localparam logic [N_IN-1:0]   LAST_VEC  = {N_IN{1'b1}};
    localparam logic [N_IN-1:0]   VEC_ONE   = N_IN'(1);
    localparam logic [ERR_W-1:0]  ERR_ONE   = ERR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_COMPARE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    state_t              state_q,   state_d;
    logic [NVEC-1:0]     mask_q,    mask_d;
    logic                mode_q,    mode_d;
    logic [WAIT_W-1:0]   wait_q,    wait_d;
    logic [N_IN-1:0]     dut_in_q,  dut_in_d;
    logic                busy_q,    busy_d;
    logic                done_q,    done_d;
    logic                pass_q,    pass_d;
    logic [ERR_W-1:0]    err_q,     err_d;
    logic                ffv_q,     ffv_d;
    logic [N_IN-1:0]     ffi_q,     ffi_d;

    // Compare result for the vector currently on dut_in; it is only acted on
    // in COMPARE, after the vector has been stable for SETTLE cycles.
    logic mismatch;
    logic last_vec;

    assign mismatch = (dut_out != mask_q[dut_in_q]);
    assign last_vec = (dut_in_q == LAST_VEC);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        mode_d   = mode_q;
        wait_d   = wait_q;
        dut_in_d = dut_in_q;
        busy_d   = busy_q;
        done_d   = done_q;
        err_d    = err_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // A restart from DONE behaves exactly like a start from IDLE:
                // the previous results are cleared on the accepting edge.
                if (start) begin
                    state_d  = S_SETTLE;
                    mask_d   = exp_mask;
                    mode_d   = stop_on_fail;
                    wait_d   = WAIT_LOAD;
                    dut_in_d = '0;
                    busy_d   = 1'b1;
                    done_d   = 1'b0;
                    err_d    = '0;
                    ffv_d    = 1'b0;
                    ffi_d    = '0;
                end
            end

            S_SETTLE: begin
                if (wait_q == WAIT_ONE) begin
                    state_d = S_COMPARE;
                end else begin
                    wait_d = wait_q - WAIT_ONE;
                end
            end

            S_COMPARE: begin
                if (mismatch) begin
                    // Cannot overflow: at most one increment per vector and
                    // the counter is one bit wider than the vector index.
                    err_d = err_q + ERR_ONE;
                    if (!ffv_q) begin
                        ffv_d = 1'b1;
                        ffi_d = dut_in_q;
                    end
                end

                if ((mismatch && mode_q) || last_vec) begin
                    // dut_in is left on the final (or failing) vector.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = S_SETTLE;
                    dut_in_d = dut_in_q + VEC_ONE;
                    wait_d   = WAIT_LOAD;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Registered so pass lines up with done and never glitches.
        pass_d = done_d && (err_d == '0);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            mask_q   <= DEF_MASK;
            mode_q   <= 1'b0;
            wait_q   <= '0;
            dut_in_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            ffv_q    <= 1'b0;
            ffi_q    <= '0;
        end else begin
            state_q  <= state_d;
            mask_q   <= mask_d;
            mode_q   <= mode_d;
            wait_q   <= wait_d;
            dut_in_q <= dut_in_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
        end
    end

    assign dut_in           = dut_in_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_valid = ffv_q;
    assign first_fail_idx   = ffi_q;

endmodule

// File: tb/tb_minterm_sweep_checker.sv
// -----------------------------------------------------------------------------
// tb_minterm_sweep_checker
//
// Directed bench for minterm_sweep_checker with its default parameters. The
// DUT under test is a behavioural sum-of-minterms model (model_mask) with an
// optional per-vector fault overlay (fault_mask). Expected sweep results are
// predicted when a sweep is launched, queued, and compared when done rises.
// -----------------------------------------------------------------------------
module tb_minterm_sweep_checker;

    localparam int N_IN = 4;
    localparam int SETTLE = 2;
    localparam int NVEC = 1 << N_IN;
    localparam int PER = SETTLE + 1;
    localparam int LIMIT = 200;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                stop_on_fail = 1'b0;
    logic [NVEC-1:0]     exp_mask = '0;
    logic                dut_out;
    logic [N_IN-1:0]     dut_in;
    logic                busy;
    logic                done;
    logic                pass;
    logic [N_IN:0]       err_count;
    logic                first_fail_valid;
    logic [N_IN-1:0]     first_fail_idx;

    logic [NVEC-1:0]     model_mask = 16'hDF03;
    logic [NVEC-1:0]     fault_mask = '0;

    int n_assert = 0;
    int n_fail = 0;

    typedef struct {
        int done_edge;
        int err;
        int ffv;
        int ffi;
        int pass;
        int last_in;
    } exp_t;

    exp_t sb[$];

    assign dut_out = model_mask[dut_in] ^ fault_mask[dut_in];

    always #5 clk = ~clk;

    minterm_sweep_checker #(
        .N_IN     (N_IN),
        .SETTLE   (SETTLE),
        .DEF_MASK (16'hDF03)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .stop_on_fail     (stop_on_fail),
        .exp_mask         (exp_mask),
        .dut_out          (dut_out),
        .dut_in           (dut_in),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_count        (err_count),
        .first_fail_valid (first_fail_valid),
        .first_fail_idx   (first_fail_idx)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference prediction of a sweep's outcome, from the truth table, the
    // model output and the fault overlay.
    function automatic exp_t predict(input logic [NVEC-1:0] em, input logic [NVEC-1:0] mm,
                                     input logic [NVEC-1:0] fm, input bit sof);
        exp_t e;
        bit stopped;
        e.err = 0;
        e.ffv = 0;
        e.ffi = 0;
        e.done_edge = NVEC * PER;
        e.last_in = NVEC - 1;
        stopped = 1'b0;
        for (int k = 0; k < NVEC; k++) begin
            if (!stopped && ((mm[k] ^ fm[k]) != em[k])) begin
                e.err++;
                if (e.ffv == 0) begin
                    e.ffv = 1;
                    e.ffi = k;
                end
                if (sof) begin
                    e.done_edge = (k + 1) * PER;
                    e.last_in = k;
                    stopped = 1'b1;
                end
            end
        end
        e.pass = (e.err == 0) ? 1 : 0;
        return e;
    endfunction

    function automatic int outs_packed();
        return int'({dut_in, busy, done, pass, err_count, first_fail_valid, first_fail_idx});
    endfunction

    // Launch a sweep and follow it to done. pa/pb are edges (counted from the
    // accepting edge 0) at which an extra start pulse is applied.
    task automatic run_sweep(input string tag, input logic [NVEC-1:0] em,
                             input logic [NVEC-1:0] mm, input logic [NVEC-1:0] fm,
                             input bit sof, input int pa, input int pb, input bit step_chk);
        exp_t e;
        int c;
        int bad_step;
        int both;
        logic [N_IN-1:0] held_in;
        model_mask = mm;
        fault_mask = fm;
        @(negedge clk);
        exp_mask = em;
        stop_on_fail = sof;
        start = 1'b1;
        sb.push_back(predict(em, mm, fm, sof));
        @(posedge clk);
        #1;
        start = 1'b0;
        // Right after the accepting edge: busy, everything else cleared.
        check({tag, ".accept"}, outs_packed(),
              int'({{N_IN{1'b0}}, 1'b1, 1'b0, 1'b0, {(N_IN+1){1'b0}}, 1'b0, {N_IN{1'b0}}}));
        // Mid-sweep changes to the latched inputs must not matter.
        exp_mask = ~em;
        stop_on_fail = ~sof;
        c = 0;
        bad_step = 0;
        both = 0;
        while (c < LIMIT && !done) begin
            @(negedge clk);
            start = ((c + 1) == pa) || ((c + 1) == pb);
            @(posedge clk);
            #1;
            c++;
            if (busy && done) both++;
            if (step_chk && !done && (int'(dut_in) != c / PER)) bad_step++;
        end
        start = 1'b0;
        e = sb.pop_front();
        check({tag, ".done_edge"}, c, e.done_edge);
        check({tag, ".err_count"}, int'(err_count), e.err);
        check({tag, ".ff_valid"}, int'(first_fail_valid), e.ffv);
        check({tag, ".ff_idx"}, int'(first_fail_idx), e.ffi);
        check({tag, ".pass"}, int'(pass), e.pass);
        check({tag, ".dut_in_final"}, int'(dut_in), e.last_in);
        check({tag, ".busy_done_overlap"}, both, 0);
        if (step_chk) check({tag, ".dut_in_steps"}, bad_step, 0);
        held_in = dut_in;
        @(posedge clk);
        #1;
        check({tag, ".done_held"}, int'({done, busy, dut_in}), int'({1'b1, 1'b0, held_in}));
    endtask

    initial begin
        // Reset state, applied asynchronously away from any clock edge.
        #2 rst = 1'b1;
        #1;
        check("reset.outputs", outs_packed(), 0);
        @(negedge clk);
        rst = 1'b0;

        run_sweep("golden", 16'hDF03, 16'hDF03, 16'h0000, 1'b0, 0, 0, 1'b1);
        run_sweep("fault13", 16'hDF03, 16'hDF03, 16'h2000, 1'b0, 0, 0, 1'b0);
        run_sweep("sof_2_9", 16'hDF03, 16'hDF03, 16'h0204, 1'b1, 0, 0, 1'b0);
        run_sweep("inverted", 16'hDF03, 16'hDF03, 16'hFFFF, 1'b0, 0, 0, 1'b0);

        // Reset in the middle of a sweep that has already logged an error.
        model_mask = 16'hDF03;
        fault_mask = 16'h0004;
        @(negedge clk);
        exp_mask = 16'hDF03;
        stop_on_fail = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("midreset.pre_in", int'(dut_in), 20 / PER);
        check("midreset.pre_err", int'(err_count), 1);
        #2 rst = 1'b1;
        #1;
        check("midreset.outputs", outs_packed(), 0);
        @(negedge clk);
        rst = 1'b0;
        run_sweep("after_reset", 16'hDF03, 16'hDF03, 16'h0000, 1'b0, 0, 0, 1'b1);

        run_sweep("ignored_start", 16'hDF03, 16'hDF03, 16'h0000, 1'b0, 5, 30, 1'b1);
        run_sweep("restart_zero", 16'h0000, 16'hDF03, 16'h0000, 1'b0, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
